// File: rtl/des3_round_engine_if.sv
// Block handshake bundle for des3_round_engine; the engine uses the slave modport.
interface des3_round_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] data_out;
  logic        busy;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/des3_round_engine.sv
// Iterative triple-DES engine: one Feistel round per clock, 48 rounds per block.
// Macro DES3_ROUND_ENGINE_SINGLE_DES_EN adds a single_des input selecting a 16-round single-DES pass.
module des3_round_engine (
  input  logic                clk,
  input  logic                rst,
`ifdef DES3_ROUND_ENGINE_SINGLE_DES_EN
  input  logic                single_des,
`endif
  input  logic [0:15][0:47]   round_keys_1,
  input  logic [0:15][0:47]   round_keys_2,
  input  logic [0:15][0:47]   round_keys_3,
  des3_round_engine_if.slave  bus
);
  // Tables hold 1-based source bit positions, bit 1 = MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,  0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,  3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,  1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,  3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,  4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,  6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,  1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,  2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [0:63] ip(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[IP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:63] fp(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:5]  b;
    logic [0:31] s;
    logic [0:31] y;
    for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1] ^ k[i];
    for (int n = 0; n < 8; n++) begin
      b = x[6*n +: 6];
      s[4*n +: 4] = 4'(SBOX[n][{b[0], b[5], b[1:4]}]);
    end
    for (int i = 0; i < 32; i++) y[i] = s[P_T[i] - 1];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [1:0]  stage_p0;
  logic [3:0]  round_p0;
  logic [0:31] l_p0;
  logic [0:31] r_p0;
  logic [0:47] rk;
  logic [0:31] l_next;
  logic [0:31] r_next;
  logic        last_stage;

`ifdef DES3_ROUND_ENGINE_SINGLE_DES_EN
  logic        single_p0;
  assign last_stage = (stage_p0 == 2'd2) || single_p0;
`else
  assign last_stage = (stage_p0 == 2'd2);
`endif

  // Middle stage walks its schedule backwards so the engine stays direction-agnostic.
  always_comb begin
    rk = round_keys_1[round_p0];
    if (stage_p0 == 2'd1)      rk = round_keys_2[4'd15 - round_p0];
    else if (stage_p0 == 2'd2) rk = round_keys_3[round_p0];
    l_next = r_p0;
    r_next = l_p0 ^ feistel(r_p0, rk);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stage_p0      <= 2'd0;
      round_p0      <= 4'd0;
      l_p0          <= '0;
      r_p0          <= '0;
      bus.data_out  <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef DES3_ROUND_ENGINE_SINGLE_DES_EN
      single_p0     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          {l_p0, r_p0} <= ip(bus.data_in);
          stage_p0     <= 2'd0;
          round_p0     <= 4'd0;
          state        <= RUN;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
`ifdef DES3_ROUND_ENGINE_SINGLE_DES_EN
          single_p0    <= single_des;
`endif
        end
        RUN: begin
          round_p0 <= round_p0 + 4'd1;
          if (round_p0 != 4'd15) begin
            l_p0 <= l_next;
            r_p0 <= r_next;
          end else if (last_stage) begin
            bus.data_out  <= fp({r_next, l_next});
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            // FP then IP between stages cancel, leaving only the final half swap.
            l_p0     <= r_next;
            r_p0     <= l_next;
            stage_p0 <= stage_p0 + 2'd1;
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
